// File: rtl/uart_receiver.sv
// 8N1 UART receiver: 2-FF synchroniser, mid-bit majority-vote sampling FSM,
// and a show-ahead receive FIFO with sticky overrun/framing error flags.
module uart_receiver #(
  parameter int unsigned CLKS_PER_BIT = 87,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rx,
  input  logic                          rd_en,
  input  logic                          err_clr,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          rx_busy,
  output logic                          overrun_err,
  output logic                          frame_err
);

  localparam int unsigned CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNTF_W = PTR_W + 1;
  localparam int unsigned HALF   = CLKS_PER_BIT / 2;

  localparam logic [CNT_W-1:0]  CNT_S0   = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0]  CNT_S1   = CNT_W'(HALF);
  localparam logic [CNT_W-1:0]  CNT_DEC  = CNT_W'(HALF + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNTF_W-1:0] CNT_FULL = CNTF_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BRK
  } state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [2:0]        idx_q;
  logic [7:0]        shift_q;
  logic [1:0]        samp_q;
  logic              busy_q;

  logic              rx_meta_q;
  logic              rx_s_q;
  logic              rx_prev_q;

  logic              vote_c;
  logic              decide_c;
  logic              bit_end_c;
  logic              push_c;
  logic              frame_set_c;

  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNTF_W-1:0] count_q, count_d;
  logic [7:0]        head_q, head_d;
  logic              valid_q;
  logic              pop_c;
  logic              full_c;
  logic              wr_ok_c;
  logic              overrun_set_c;
  logic              overrun_q;
  logic              frame_q;

  // Two-stage synchroniser plus one-cycle delayed copy for falling-edge detection
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
    end
  end

  // Third sample is the live synchronised bit on the decision cycle
  assign vote_c      = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s_q) | (samp_q[1] & rx_s_q);
  assign decide_c    = (cnt_q == CNT_DEC);
  assign bit_end_c   = (cnt_q == CNT_LAST);
  assign push_c      = (state_q == S_STOP) && decide_c && vote_c;
  assign frame_set_c = (state_q == S_STOP) && decide_c && !vote_c;

  // Receive FSM
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      samp_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      if (cnt_q == CNT_S0) samp_q[0] <= rx_s_q;
      if (cnt_q == CNT_S1) samp_q[1] <= rx_s_q;
      unique case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (rx_prev_q && !rx_s_q) begin
            state_q <= S_START;
            busy_q  <= 1'b1;
          end
        end
        S_START: begin
          if (decide_c && vote_c) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else if (bit_end_c) begin
            state_q <= S_DATA;
            cnt_q   <= '0;
            idx_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (decide_c) shift_q <= {vote_c, shift_q[7:1]};
          if (bit_end_c) begin
            cnt_q <= '0;
            if (idx_q == 3'd7) state_q <= S_STOP;
            else               idx_q   <= idx_q + 3'd1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_STOP: begin
          if (decide_c) begin
            cnt_q <= '0;
            if (vote_c) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= S_BRK;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_BRK: begin
          if (rx_s_q) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign pop_c         = rd_en && valid_q;
  assign full_c        = (count_q == CNT_FULL);
  assign wr_ok_c       = push_c && (!full_c || pop_c);
  assign overrun_set_c = push_c && full_c && !pop_c;

  // FIFO next state; head register pre-loads the entry that will be at the front next cycle
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    head_d   = head_q;
    count_d  = count_q + CNTF_W'(wr_ok_c) - CNTF_W'(pop_c);
    if (wr_ok_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_c)   rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (wr_ok_c && ((count_q - CNTF_W'(pop_c)) == '0)) head_d = shift_q;
    else if (count_d != '0)                            head_d = mem_q[rd_ptr_d];
  end

  always_ff @(posedge clk) begin
    if (wr_ok_c) mem_q[wr_ptr_q] <= shift_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      valid_q  <= (count_d != '0);
    end
  end

  // Sticky error flags; a set event outranks a same-cycle clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overrun_q <= 1'b0;
      frame_q   <= 1'b0;
    end else begin
      if (overrun_set_c) overrun_q <= 1'b1;
      else if (err_clr)  overrun_q <= 1'b0;
      if (frame_set_c)   frame_q   <= 1'b1;
      else if (err_clr)  frame_q   <= 1'b0;
    end
  end

  assign rx_data     = head_q;
  assign rx_valid    = valid_q;
  assign fifo_count  = count_q;
  assign rx_busy     = busy_q;
  assign overrun_err = overrun_q;
  assign frame_err   = frame_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed testbench for uart_receiver at 87 clocks per bit with a 4-entry FIFO.
module tb_uart_receiver;

  localparam int CPB = 87;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic       rd_en;
  logic       err_clr;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [2:0] fifo_count;
  logic       rx_busy;
  logic       overrun_err;
  logic       frame_err;

  int total = 0;
  int bad   = 0;

  uart_receiver #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .rd_en      (rd_en),
    .err_clr    (err_clr),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .fifo_count (fifo_count),
    .rx_busy    (rx_busy),
    .overrun_err(overrun_err),
    .frame_err  (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called 1 time unit after a rising edge; each bit is held for CPB edges.
  // spike_bit selects a data bit that gets a one-cycle high pulse at its centre.
  task automatic send_byte(input logic [7:0] b, input logic stop_v, input int spike_bit);
    rx = 1'b0;
    repeat (CPB) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      if (spike_bit == i) begin
        repeat (43) @(posedge clk);
        #1 rx = 1'b1;
        @(posedge clk);
        #1 rx = b[i];
        repeat (CPB - 44) @(posedge clk);
        #1;
      end else begin
        repeat (CPB) @(posedge clk);
        #1;
      end
    end
    rx = stop_v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic do_pop();
    rd_en = 1'b1;
    @(posedge clk);
    #1 rd_en = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", rx_valid); end
    total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", rx_data); end
    total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
    total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", rx_busy); end
    total++; if ({overrun_err, frame_err} !== 2'b00) begin bad++; $display("FAIL reset_errs got=%b exp=00", {overrun_err, frame_err}); end
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    send_byte(8'hA5, 1'b1, -1);
    total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b exp=1", rx_valid); end
    total++; if (rx_data !== 8'hA5) begin bad++; $display("FAIL single_data got=%h exp=a5", rx_data); end
    total++; if (fifo_count !== 3'd1) begin bad++; $display("FAIL single_count got=%0d exp=1", fifo_count); end
    do_pop();
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL single_pop_valid got=%b exp=0", rx_valid); end
    do_pop();
    total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL empty_pop_count got=%0d exp=0", fifo_count); end
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL empty_pop_valid got=%b exp=0", rx_valid); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [4];
    exp = '{8'h00, 8'hFF, 8'h55, 8'h3C};
    for (int i = 0; i < 4; i++) send_byte(exp[i], 1'b1, -1);
    total++; if (fifo_count !== 3'd4) begin bad++; $display("FAIL b2b_count got=%0d exp=4", fifo_count); end
    total++; if (overrun_err !== 1'b0) begin bad++; $display("FAIL b2b_no_overrun got=%b exp=0", overrun_err); end
    send_byte(8'h11, 1'b1, -1);
    total++; if (overrun_err !== 1'b1) begin bad++; $display("FAIL overrun_set got=%b exp=1", overrun_err); end
    total++; if (fifo_count !== 3'd4) begin bad++; $display("FAIL overrun_count got=%0d exp=4", fifo_count); end
    total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL overrun_head got=%h exp=00", rx_data); end
    pulse_clr();
    total++; if (overrun_err !== 1'b0) begin bad++; $display("FAIL overrun_clr got=%b exp=0", overrun_err); end
    for (int i = 0; i < 4; i++) begin
      total++; if (rx_data !== exp[i]) begin bad++; $display("FAIL b2b_pop%0d got=%h exp=%h", i, rx_data, exp[i]); end
      do_pop();
    end
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL b2b_drained got=%b exp=0", rx_valid); end
  endtask

  task automatic test_glitch();
    rx = 1'b0;
    repeat (20) @(posedge clk);
    #1 rx = 1'b1;
    total++; if (rx_busy !== 1'b1) begin bad++; $display("FAIL glitch_busy got=%b exp=1", rx_busy); end
    repeat (100) @(posedge clk);
    #1;
    total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL glitch_idle got=%b exp=0", rx_busy); end
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL glitch_nobyte got=%b exp=0", rx_valid); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL glitch_noerr got=%b exp=0", frame_err); end
    send_byte(8'h00, 1'b1, 3);
    total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL spike_valid got=%b exp=1", rx_valid); end
    total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL spike_data got=%h exp=00", rx_data); end
    do_pop();
  endtask

  task automatic test_frame_err();
    send_byte(8'h41, 1'b0, -1);
    repeat (1000) @(posedge clk);
    #1;
    total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL frame_set got=%b exp=1", frame_err); end
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL frame_nopush got=%b exp=0", rx_valid); end
    total++; if (rx_busy !== 1'b1) begin bad++; $display("FAIL frame_busy got=%b exp=1", rx_busy); end
    rx = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL frame_release got=%b exp=0", rx_busy); end
    send_byte(8'h42, 1'b1, -1);
    total++; if (rx_data !== 8'h42) begin bad++; $display("FAIL frame_next_data got=%h exp=42", rx_data); end
    total++; if (fifo_count !== 3'd1) begin bad++; $display("FAIL frame_next_count got=%0d exp=1", fifo_count); end
    total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL frame_sticky got=%b exp=1", frame_err); end
    pulse_clr();
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL frame_clr got=%b exp=0", frame_err); end
    do_pop();
  endtask

  task automatic test_full_pop_push();
    logic [7:0] exp [4];
    exp = '{8'h02, 8'h03, 8'h04, 8'h77};
    send_byte(8'h01, 1'b1, -1);
    for (int i = 0; i < 3; i++) send_byte(exp[i], 1'b1, -1);
    total++; if (fifo_count !== 3'd4) begin bad++; $display("FAIL full_pre_count got=%0d exp=4", fifo_count); end
    // Stop-bit decision lands on the 831st edge after the start bit is driven
    fork
      send_byte(8'h77, 1'b1, -1);
      begin
        repeat (830) @(posedge clk);
        #1 rd_en = 1'b1;
        @(posedge clk);
        #1 rd_en = 1'b0;
      end
    join
    total++; if (overrun_err !== 1'b0) begin bad++; $display("FAIL full_no_overrun got=%b exp=0", overrun_err); end
    total++; if (fifo_count !== 3'd4) begin bad++; $display("FAIL full_count got=%0d exp=4", fifo_count); end
    for (int i = 0; i < 4; i++) begin
      total++; if (rx_data !== exp[i]) begin bad++; $display("FAIL full_pop%0d got=%h exp=%h", i, rx_data, exp[i]); end
      do_pop();
    end
  endtask

  task automatic test_reset_mid_frame();
    send_byte(8'h5A, 1'b1, -1);
    total++; if (fifo_count !== 3'd1) begin bad++; $display("FAIL midrst_pre_count got=%0d exp=1", fifo_count); end
    // 0xF0 keeps the line high from data bit 4 on, so no false start after reset
    fork
      send_byte(8'hF0, 1'b1, -1);
      begin
        repeat (479) @(posedge clk);
        #1;
        total++; if (rx_busy !== 1'b1) begin bad++; $display("FAIL midrst_busy_before got=%b exp=1", rx_busy); end
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
      end
    join
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b exp=0", rx_valid); end
    total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL midrst_count got=%0d exp=0", fifo_count); end
    total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b exp=0", rx_busy); end
    send_byte(8'h9C, 1'b1, -1);
    total++; if (rx_data !== 8'h9C) begin bad++; $display("FAIL midrst_next_data got=%h exp=9c", rx_data); end
    total++; if (fifo_count !== 3'd1) begin bad++; $display("FAIL midrst_next_count got=%0d exp=1", fifo_count); end
  endtask

  initial begin
    rst_n   = 1'b0;
    rx      = 1'b1;
    rd_en   = 1'b0;
    err_clr = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_full_pop_push();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
